// File: rtl/conbus_defs.sv
// Shared sizing constants and helpers for the four-master conbus arbiter.
package conbus_defs;

    localparam int NMASTERS = 4;
    localparam int CNT_W    = 16;
    localparam int IDX_W    = 2;
    localparam int ADR_W    = 32;
    localparam int DAT_W    = 32;
    localparam int SEL_W    = 4;
    localparam int CTI_W    = 3;

    typedef logic [NMASTERS-1:0] mvec_t;

    function automatic logic [IDX_W-1:0] onehot_to_idx(input mvec_t oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NMASTERS; i++) begin
            if (oh[i]) idx = idx | IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/conbus_rr_pick.sv
// Rotating next-grant search: first requester after the current owner, else hold the current grant.
module conbus_rr_pick
    import conbus_defs::*;
(
    input  logic [NMASTERS-1:0] gnt,
    input  logic [NMASTERS-1:0] m_cyc,
    output logic [NMASTERS-1:0] next
);

    logic [IDX_W-1:0] cur;
    logic [IDX_W-1:0] idx;
    logic             found;

    assign cur = onehot_to_idx(gnt);

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        next  = gnt;
        found = 1'b0;
        idx   = cur;
        for (int k = 1; k < NMASTERS; k++) begin
            idx = cur + IDX_W'(k);
            if (!found && m_cyc[idx]) begin
                next      = '0;
                next[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/conbus_rr_arb.sv
// Four-master Wishbone round-robin arbiter: per-cycle bus lock, combinational
// routing of the granted master, and a wait-state timeout that raises a bus error.
module conbus_rr_arb
    import conbus_defs::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic [NMASTERS*ADR_W-1:0] m_adr,
    input  logic [NMASTERS*DAT_W-1:0] m_dat_w,
    input  logic [NMASTERS*SEL_W-1:0] m_sel,
    input  logic [NMASTERS*CTI_W-1:0] m_cti,
    input  logic [NMASTERS-1:0]       m_we,
    input  logic [NMASTERS-1:0]       m_cyc,
    input  logic [NMASTERS-1:0]       m_stb,
    output logic [DAT_W-1:0]          m_dat_r,
    output logic [NMASTERS-1:0]       m_ack,
    output logic [NMASTERS-1:0]       m_err,
    output logic [ADR_W-1:0]          s_adr,
    output logic [DAT_W-1:0]          s_dat_w,
    output logic [SEL_W-1:0]          s_sel,
    output logic [CTI_W-1:0]          s_cti,
    output logic                      s_we,
    output logic                      s_cyc,
    output logic                      s_stb,
    input  logic [DAT_W-1:0]          s_dat_r,
    input  logic                      s_ack,
    output logic [NMASTERS-1:0]       gnt
);

    logic [ADR_W-1:0] adr_a [NMASTERS];
    logic [DAT_W-1:0] dat_a [NMASTERS];
    logic [SEL_W-1:0] sel_a [NMASTERS];
    logic [CTI_W-1:0] cti_a [NMASTERS];

    for (genvar i = 0; i < NMASTERS; i++) begin : g_slice
        assign adr_a[i] = m_adr[i*ADR_W +: ADR_W];
        assign dat_a[i] = m_dat_w[i*DAT_W +: DAT_W];
        assign sel_a[i] = m_sel[i*SEL_W +: SEL_W];
        assign cti_a[i] = m_cti[i*CTI_W +: CTI_W];
    end

    logic [IDX_W-1:0]    g;
    logic [NMASTERS-1:0] gnt_next;
    logic [CNT_W-1:0]    wait_cnt;
    logic                cur_cyc;
    logic                cur_stb;
    logic                active;
    logic                timeout_fire;
    logic                gnt_change;

    assign g            = onehot_to_idx(gnt);
    assign cur_cyc      = m_cyc[g];
    assign cur_stb      = m_stb[g];
    assign active       = cur_cyc & cur_stb;
    assign timeout_fire = active & ~s_ack & (wait_cnt == CNT_W'(TIMEOUT - 1));
    assign gnt_change   = ~cur_cyc & (gnt_next != gnt);

    assign s_adr   = adr_a[g];
    assign s_dat_w = dat_a[g];
    assign s_sel   = sel_a[g];
    assign s_cti   = cti_a[g];
    assign s_we    = m_we[g];
    // The erroring cycle is withdrawn from the slave so it never sees a late strobe.
    assign s_cyc   = cur_cyc & ~timeout_fire;
    assign s_stb   = cur_stb & ~timeout_fire;

    assign m_dat_r = s_dat_r;
    assign m_ack   = {NMASTERS{s_ack}} & gnt & m_cyc & m_stb;
    assign m_err   = timeout_fire ? gnt : '0;

    conbus_rr_pick u_pick (
        .gnt   (gnt),
        .m_cyc (m_cyc),
        .next  (gnt_next)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            gnt      <= NMASTERS'(1);
            wait_cnt <= '0;
        end else begin
            if (!cur_cyc) gnt <= gnt_next;
            if (!active || s_ack || timeout_fire || gnt_change) wait_cnt <= '0;
            else                                                wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_conbus_rr_arb.sv
// Self-checking bench for conbus_rr_arb: routing vector table, round-robin order,
// bus lock, timeout error, ack-over-timeout priority and mid-cycle reset.
module tb_conbus_rr_arb;
    import conbus_defs::*;

    localparam int TO = 8;

    logic                      sys_clk = 1'b0;
    logic                      sys_rst = 1'b1;
    logic [NMASTERS*ADR_W-1:0] m_adr;
    logic [NMASTERS*DAT_W-1:0] m_dat_w;
    logic [NMASTERS*SEL_W-1:0] m_sel;
    logic [NMASTERS*CTI_W-1:0] m_cti;
    logic [NMASTERS-1:0]       m_we;
    logic [NMASTERS-1:0]       m_cyc = '0;
    logic [NMASTERS-1:0]       m_stb = '0;
    logic [DAT_W-1:0]          m_dat_r;
    logic [NMASTERS-1:0]       m_ack;
    logic [NMASTERS-1:0]       m_err;
    logic [ADR_W-1:0]          s_adr;
    logic [DAT_W-1:0]          s_dat_w;
    logic [SEL_W-1:0]          s_sel;
    logic [CTI_W-1:0]          s_cti;
    logic                      s_we;
    logic                      s_cyc;
    logic                      s_stb;
    logic [DAT_W-1:0]          s_dat_r = '0;
    logic                      s_ack = 1'b0;
    logic [NMASTERS-1:0]       gnt;

    typedef struct packed {
        logic [3:0] cyc;
        logic [3:0] stb;
        logic       ack;
        logic [3:0] e_ack;
        logic [3:0] e_err;
        logic       e_scyc;
        logic       e_sstb;
    } vec_t;

    typedef struct packed {
        logic [1:0] idx;
        logic [3:0] e_ack;
        logic [3:0] e_err;
        logic       e_scyc;
        logic       e_sstb;
    } exp_t;

    vec_t vecs [6];
    exp_t exp_q [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    conbus_rr_arb #(.TIMEOUT(TO)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .m_adr   (m_adr),
        .m_dat_w (m_dat_w),
        .m_sel   (m_sel),
        .m_cti   (m_cti),
        .m_we    (m_we),
        .m_cyc   (m_cyc),
        .m_stb   (m_stb),
        .m_dat_r (m_dat_r),
        .m_ack   (m_ack),
        .m_err   (m_err),
        .s_adr   (s_adr),
        .s_dat_w (s_dat_w),
        .s_sel   (s_sel),
        .s_cti   (s_cti),
        .s_we    (s_we),
        .s_cyc   (s_cyc),
        .s_stb   (s_stb),
        .s_dat_r (s_dat_r),
        .s_ack   (s_ack),
        .gnt     (gnt)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic logic [31:0] adr_of(input int k);
        return 32'hA000_0000 + 32'(k) * 32'h0101_0101;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic compare_exp(input string tag, input exp_t e);
        check({tag, "_ack"},  32'(m_ack),  32'(e.e_ack));
        check({tag, "_err"},  32'(m_err),  32'(e.e_err));
        check({tag, "_scyc"}, 32'(s_cyc),  32'(e.e_scyc));
        check({tag, "_sstb"}, 32'(s_stb),  32'(e.e_sstb));
        check({tag, "_adr"},  s_adr,       adr_of(int'(e.idx)));
        check({tag, "_datw"}, s_dat_w,     ~adr_of(int'(e.idx)));
        check({tag, "_sel"},  32'(s_sel),  32'(e.idx) + 32'd1);
        check({tag, "_cti"},  32'(s_cti),  32'(e.idx));
        check({tag, "_we"},   32'(s_we),   32'(e.idx[0]));
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        m_cyc   = '0;
        m_stb   = '0;
        s_ack   = 1'b0;
        tick();
        sys_rst = 1'b0;
    endtask

    // Invariants that must hold in every cycle outside reset.
    always @(negedge sys_clk) begin
        if (sys_rst === 1'b0) begin
            check("gnt_onehot",   32'($onehot(gnt)), 32'd1);
            check("ack_err_excl", 32'(m_ack & m_err), 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  drop;
        logic [31:0] rd;
        logic        prev_scyc;
        logic        err_seen;
        exp_t        e;
        int          acks;
        int          last_n;
        int          err_at;

        for (int k = 0; k < NMASTERS; k++) begin
            m_adr[k*ADR_W +: ADR_W]   = adr_of(k);
            m_dat_w[k*DAT_W +: DAT_W] = ~adr_of(k);
            m_sel[k*SEL_W +: SEL_W]   = SEL_W'(k + 1);
            m_cti[k*CTI_W +: CTI_W]   = CTI_W'(k);
        end
        m_we = 4'b1010;

        // Routing vectors with master 0 owning the bus.
        vecs[0] = '{4'b0001, 4'b0001, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1};
        vecs[1] = '{4'b0001, 4'b0001, 1'b1, 4'b0001, 4'b0000, 1'b1, 1'b1};
        vecs[2] = '{4'b0000, 4'b0001, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1};
        vecs[3] = '{4'b1111, 4'b1110, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0};
        vecs[4] = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 4'b0000, 1'b1, 1'b1};
        vecs[5] = '{4'b1110, 4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1};

        // Reset state with every master idle.
        sys_rst = 1'b1;
        tick();
        tick();
        sys_rst = 1'b0;
        check("rst_gnt",  32'(gnt),   32'b0001);
        check("rst_scyc", 32'(s_cyc), 32'd0);
        check("rst_ack",  32'(m_ack), 32'd0);
        check("rst_err",  32'(m_err), 32'd0);

        // Table vectors are applied between edges so the grant cannot move.
        for (int i = 0; i < 6; i++) begin
            m_cyc   = vecs[i].cyc;
            m_stb   = vecs[i].stb;
            s_ack   = vecs[i].ack;
            rd      = $urandom();
            s_dat_r = rd;
            exp_q.push_back('{2'd0, vecs[i].e_ack, vecs[i].e_err, vecs[i].e_scyc, vecs[i].e_sstb});
            #1;
            e = exp_q.pop_front();
            compare_exp($sformatf("vec%0d", i), e);
            check($sformatf("vec%0d_datr", i), m_dat_r, rd);
        end
        m_cyc = '0;
        m_stb = '0;
        s_ack = 1'b0;
        tick();

        // Round robin: all masters request, each drops cyc for one cycle after its ack.
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back('{2'(k % 4), 4'(1 << (k % 4)), 4'b0000, 1'b1, 1'b1});
        end
        drop      = '0;
        acks      = 0;
        last_n    = 0;
        prev_scyc = 1'b0;
        for (int n = 0; n < 40 && acks < 5; n++) begin
            m_cyc = ~drop;
            m_stb = ~drop;
            s_ack = 1'b1;
            @(negedge sys_clk);
            if (m_ack != '0) begin
                e = exp_q.pop_front();
                compare_exp($sformatf("rr%0d", acks), e);
                check($sformatf("rr%0d_gnt", acks), 32'(gnt), 32'(e.e_ack));
                if (acks > 0) begin
                    check($sformatf("rr%0d_gap", acks), 32'(n - last_n), 32'd2);
                    check($sformatf("rr%0d_idle", acks), 32'(prev_scyc), 32'd0);
                end
                last_n = n;
                acks++;
            end
            prev_scyc = s_cyc;
            drop      = m_ack;
            tick();
        end
        check("rr_ack_count", 32'(acks), 32'd5);
        exp_q.delete();

        // Bus lock: master 2 keeps cyc for 10 transfers while everyone else requests.
        do_reset();
        m_cyc = 4'b0100;
        m_stb = 4'b0100;
        tick();
        check("lock_gnt_start", 32'(gnt), 32'b0100);
        m_cyc = 4'b1111;
        m_stb = 4'b0100;
        s_ack = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk);
            check($sformatf("lock%0d_gnt", i), 32'(gnt),   32'b0100);
            check($sformatf("lock%0d_ack", i), 32'(m_ack), 32'b0100);
            tick();
        end
        m_cyc = 4'b1011;
        m_stb = '0;
        s_ack = 1'b0;
        tick();
        check("lock_gnt_next", 32'(gnt), 32'b1000);

        // Timeout: master 1 strobes and the slave never answers.
        do_reset();
        m_cyc = 4'b0010;
        m_stb = 4'b0010;
        tick();
        check("to_gnt", 32'(gnt), 32'b0010);
        err_at = 0;
        for (int w = 1; w <= 20 && err_at == 0; w++) begin
            @(negedge sys_clk);
            if (m_err != '0) begin
                err_at = w;
                check("to_err_bits", 32'(m_err), 32'b0010);
                check("to_s_cycstb", 32'({s_cyc, s_stb}), 32'd0);
                check("to_ack",      32'(m_ack), 32'd0);
            end
            tick();
        end
        check("to_err_cycle", 32'(err_at), 32'(TO));
        check("to_gnt_after", 32'(gnt), 32'b0010);

        // Ack arriving on the last allowed wait cycle wins over the timeout.
        err_seen = 1'b0;
        for (int w = 1; w <= TO; w++) begin
            s_ack = (w == TO);
            @(negedge sys_clk);
            if (m_err != '0) err_seen = 1'b1;
            if (w == TO) begin
                check("prio_ack",  32'(m_ack), 32'b0010);
                check("prio_err",  32'(m_err), 32'd0);
                check("prio_sstb", 32'(s_stb), 32'd1);
            end
            tick();
        end
        check("prio_no_early_err", 32'(err_seen), 32'd0);
        s_ack = 1'b0;

        // Reset in the middle of a stalled master-3 transfer.
        m_cyc = 4'b1000;
        m_stb = 4'b0000;
        tick();
        check("mrst_gnt_pre", 32'(gnt), 32'b1000);
        m_stb = 4'b1000;
        for (int i = 0; i < 5; i++) tick();
        sys_rst = 1'b1;
        m_cyc   = 4'b1001;
        m_stb   = 4'b1001;
        tick();
        sys_rst = 1'b0;
        check("mrst_gnt", 32'(gnt), 32'b0001);
        s_ack = 1'b1;
        #1;
        check("mrst_ack", 32'(m_ack), 32'b0001);
        s_ack  = 1'b0;
        err_at = 0;
        for (int w = 1; w <= 20 && err_at == 0; w++) begin
            @(negedge sys_clk);
            if (m_err != '0) begin
                err_at = w;
                check("mrst_err_bits", 32'(m_err), 32'b0001);
            end
            tick();
        end
        check("mrst_cnt_cleared", 32'(err_at), 32'(TO));

        m_cyc = '0;
        m_stb = '0;
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
